// File: rtl/mul_pkg.sv
// Shared multiplier types: Booth digit encoding and the recode helper.
// Used by booth_digit_streamer (optional BOOTH_ZERO_SKIP_EN) and its checkers.
package mul_pkg;

  localparam int WIDTH      = 16;
  localparam int NUM_DIGITS = (WIDTH + 3) / 4;

  typedef enum logic [3:0] {
    PP_0  = 4'd0,
    PP_A  = 4'd1,
    PP_2A = 4'd2,
    PP_3A = 4'd3,
    PP_4A = 4'd4,
    PP_5A = 4'd5,
    PP_6A = 4'd6,
    PP_7A = 4'd7,
    PP_8A = 4'd8
  } booth_sel_t;

  typedef struct packed {
    booth_sel_t sel;
    logic       neg;
  } booth_digit_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } bds_state_t;

  // b = {b[4i+3], b[4i+2], b[4i+1], b[4i], b[4i-1]}
  function automatic booth_digit_t booth_recode(input logic [4:0] b);
    logic signed [4:0] v;
    logic [4:0]        mag;
    booth_digit_t      d;
    v     = $signed({b[4], b[4:1]}) + $signed({4'b0000, b[0]});
    mag   = v[4] ? 5'(-v) : 5'(v);
    d.sel = booth_sel_t'(mag[3:0]);
    d.neg = v[4];
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational radix-16 Booth digit encoder: one 5-bit window to
// a {sel, neg} digit.
module booth_digit_enc
  import mul_pkg::*;
(
  input  logic [4:0]   i_bits,
  output booth_digit_t o_digit
);

  assign o_digit = booth_recode(i_bits);

endmodule

// File: rtl/booth_digit_streamer.sv
// Sequential radix-16 Booth recoder streaming digits LSB-first.
// Define BOOTH_ZERO_SKIP_EN to suppress PP_0 digits below the last index.
module booth_digit_streamer
  import mul_pkg::*;
#(
  parameter int WIDTH      = mul_pkg::WIDTH,
  parameter int NUM_DIGITS = mul_pkg::NUM_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mult_valid_in,
  output logic                          mult_ready_out,
  input  logic [WIDTH-1:0]              multiplier_in,
  output logic                          digit_valid_out,
  input  logic                          digit_ready_in,
  output booth_sel_t                    booth_sel_out,
  output logic                          neg_value_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_out,
  output logic                          digit_last_out
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int XW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic signed [XW-1:0] w_ext;
  logic [XW:0]          w_bits;
  booth_digit_t         w_enc [NUM_DIGITS];
  logic [IW-1:0]        w_first;
  logic [IW-1:0]        w_next;
  logic                 w_load;
  logic                 w_acc;

  bds_state_t    r_state;
  booth_digit_t  r_dig [NUM_DIGITS];
  logic [IW-1:0] r_idx;
  logic          r_valid;
  logic          r_last;
  booth_sel_t    r_sel;
  logic          r_neg;

  assign w_ext  = XW'($signed(multiplier_in));
  assign w_bits = {w_ext, 1'b0};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    booth_digit_enc u_enc (
      .i_bits  (w_bits[4*g +: 5]),
      .o_digit (w_enc[g])
    );
  end

`ifdef BOOTH_ZERO_SKIP_EN
  // Lowest nonzero index wins; the last index is always a fallback.
  always_comb begin
    w_first = LAST_IDX;
    w_next  = LAST_IDX;
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      if (w_enc[i].sel != PP_0)
        w_first = IW'(i);
      if ((i > int'(r_idx)) && (r_dig[i].sel != PP_0))
        w_next = IW'(i);
    end
  end
`else
  assign w_first = '0;
  assign w_next  = r_idx + 1'b1;
`endif

  assign w_acc  = r_valid & digit_ready_in;
  assign w_load = mult_valid_in & mult_ready_out;

  assign mult_ready_out = (r_state == S_IDLE)
                        | (w_acc & r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_sel   <= PP_0;
      r_neg   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
        r_dig[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        r_dig[i] <= w_enc[i];
      r_state <= S_RUN;
      r_valid <= 1'b1;
      r_idx   <= w_first;
      r_sel   <= w_enc[w_first].sel;
      r_neg   <= w_enc[w_first].neg;
      r_last  <= (w_first == LAST_IDX);
    end else if (w_acc) begin
      if (r_last) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
      end else begin
        r_idx  <= w_next;
        r_sel  <= r_dig[w_next].sel;
        r_neg  <= r_dig[w_next].neg;
        r_last <= (w_next == LAST_IDX);
      end
    end
  end

  assign digit_valid_out = r_valid;
  assign booth_sel_out   = r_sel;
  assign neg_value_out   = r_neg;
  assign digit_idx_out   = r_idx;
  assign digit_last_out  = r_last;

endmodule
